// File: rtl/cdc_request_arbiter.sv
// Round-robin arbiter that serializes NUM_REQ source-domain requesters onto one
// handshake synchronizer port, holding {id, payload} stable until accepted.
module cdc_request_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int ID_WIDTH       = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [ID_WIDTH+DATA_WIDTH-1:0] sync_data,
   output logic                          sync_valid,
   input  logic                          sync_ready,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy,
   output logic                          timeout_err,
   input  logic                          err_clr
);

   typedef enum logic {IDLE, SEND} state_e;

   state_e                         state_q, state_d;
   logic [ID_WIDTH-1:0]            ptr_q, ptr_d;
   logic [ID_WIDTH-1:0]            gid_q, gid_d;
   logic [ID_WIDTH+DATA_WIDTH-1:0] data_q, data_d;
   logic [15:0]                    cnt_q, cnt_d;
   logic                           err_q, err_d;

   logic                           any_req;
   logic [ID_WIDTH-1:0]            win;
   logic [DATA_WIDTH-1:0]          win_data;

   // Scan downward so the candidate closest to the pointer is assigned last and wins.
   always_comb begin
      int idx;
      idx     = 0;
      any_req = 1'b0;
      win     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(ptr_q) + i) % NUM_REQ;
         if (req_valid[ID_WIDTH'(idx)]) begin
            any_req = 1'b1;
            win     = ID_WIDTH'(idx);
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (win == ID_WIDTH'(j)) win_data = req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gid_d     = gid_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      req_ready = '0;
      if (err_clr) err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               req_ready[win] = 1'b1;
               data_d  = {win, win_data};
               gid_d   = win;
               ptr_d   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (sync_ready) begin
               state_d = IDLE;
            end else begin
               if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 1'b1;
               // Setting takes priority over a coincident clear.
               if (cnt_d >= 16'(TIMEOUT_CYCLES)) err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst) req_ready = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign sync_valid  = (state_q == SEND);
   assign busy        = (state_q == SEND);
   assign sync_data   = data_q;
   assign grant_id    = gid_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_cdc_request_arbiter.sv
// Bench for cdc_request_arbiter: directed vector table, hand sequences for
// backpressure/timeout/reset, then randomized traffic against a reference model.
module tb_cdc_request_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int TO = 8;
   localparam logic [31:0] D0 = 32'hA5A5_0001;
   localparam logic [31:0] D1 = 32'hB6B6_0002;
   localparam logic [31:0] D2 = 32'h0000_1234;
   localparam logic [31:0] D3 = 32'hC7C7_0004;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic [2+DW-1:0]  sync_data;
   logic             sync_valid;
   logic             sync_ready;
   logic [1:0]       grant_id;
   logic             busy;
   logic             timeout_err;
   logic             err_clr;
   logic [DW-1:0]    d [NR];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NR; g++) begin : g_data
      assign req_data[g*DW +: DW] = d[g];
   end

   cdc_request_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(2), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .sync_data(sync_data), .sync_valid(sync_valid),
      .sync_ready(sync_ready), .grant_id(grant_id), .busy(busy),
      .timeout_err(timeout_err), .err_clr(err_clr)
   );

   typedef struct {
      logic       rst;
      logic [3:0] rv;
      logic       sr;
      logic       clr;
      logic [3:0] rr;
      logic       sv;
      logic [1:0] gid;
      logic [31:0] pl;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [3:0] rv, input logic sr, input logic clr,
                      input logic [3:0] rr, input logic sv, input logic [1:0] gid,
                      input logic [31:0] pl);
      vec_t v;
      v.rst = r; v.rv = rv; v.sr = sr; v.clr = clr;
      v.rr = rr; v.sv = sv; v.gid = gid; v.pl = pl;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] rv, input logic sr, input logic clr);
      rst = r; req_valid = rv; sync_ready = sr; err_clr = clr;
   endtask

   // Compare mid-cycle, then advance past the next rising edge.
   task automatic sample(input string nm, input logic [3:0] e_rr, input logic e_sv,
                         input logic [1:0] e_gid, input logic [31:0] e_pl, input logic e_err);
      @(negedge clk);
      chk({nm, ".req_ready"},   64'(req_ready),   64'(e_rr));
      chk({nm, ".sync_valid"},  64'(sync_valid),  64'(e_sv));
      chk({nm, ".busy"},        64'(busy),        64'(e_sv));
      chk({nm, ".grant_id"},    64'(grant_id),    64'(e_gid));
      chk({nm, ".sync_data"},   64'(sync_data),   64'({e_gid, e_pl}));
      chk({nm, ".timeout_err"}, 64'(timeout_err), 64'(e_err));
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [3:0] rv, input int p);
      int j;
      for (int k = 0; k < NR; k++) begin
         j = (p + k) % NR;
         if (rv[2'(j)]) return j;
      end
      return -1;
   endfunction

   initial begin
      logic [3:0] e_rr;
      int         w;
      logic       m_send, m_err, set;
      int         m_ptr, m_wait;
      logic [1:0] m_gid;
      logic [31:0] m_pl;

      d[0] = D0; d[1] = D1; d[2] = D2; d[3] = D3;
      drive(1'b1, 4'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      //   rst  rv    sr  clr  rr     sv   gid  payload
      add(1, 4'hF, 1, 0, 4'h0, 0, 2'd0, 32'h0);
      add(0, 4'hF, 1, 0, 4'h1, 0, 2'd0, 32'h0);
      add(0, 4'hF, 1, 0, 4'h0, 1, 2'd0, D0);
      add(0, 4'hF, 1, 0, 4'h2, 0, 2'd0, D0);
      add(0, 4'hF, 1, 0, 4'h0, 1, 2'd1, D1);
      add(0, 4'hF, 1, 0, 4'h4, 0, 2'd1, D1);
      add(0, 4'hF, 1, 0, 4'h0, 1, 2'd2, D2);
      add(0, 4'hF, 1, 0, 4'h8, 0, 2'd2, D2);
      add(0, 4'hF, 1, 0, 4'h0, 1, 2'd3, D3);
      add(0, 4'hF, 1, 0, 4'h1, 0, 2'd3, D3);
      add(0, 4'hF, 1, 0, 4'h0, 1, 2'd0, D0);
      add(0, 4'hF, 1, 0, 4'h2, 0, 2'd0, D0);
      add(0, 4'hF, 1, 0, 4'h0, 1, 2'd1, D1);
      add(0, 4'h1, 1, 0, 4'h1, 0, 2'd1, D1);
      add(0, 4'h0, 1, 0, 4'h0, 1, 2'd0, D0);
      add(0, 4'h0, 1, 0, 4'h0, 0, 2'd0, D0);
      add(0, 4'h4, 1, 0, 4'h4, 0, 2'd0, D0);
      add(0, 4'h0, 1, 0, 4'h0, 1, 2'd2, D2);
      add(0, 4'h5, 1, 0, 4'h1, 0, 2'd2, D2);
      add(0, 4'h5, 0, 0, 4'h0, 1, 2'd0, D0);
      add(0, 4'h5, 1, 0, 4'h0, 1, 2'd0, D0);
      add(0, 4'h5, 1, 0, 4'h4, 0, 2'd0, D0);
      add(0, 4'h0, 1, 0, 4'h0, 1, 2'd2, D2);
      add(0, 4'h0, 1, 0, 4'h0, 0, 2'd2, D2);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].rv, tbl[i].sr, tbl[i].clr);
         sample($sformatf("vec%0d", i), tbl[i].rr, tbl[i].sv, tbl[i].gid, tbl[i].pl, 1'b0);
      end

      // Backpressure with timeout; err_clr during a stall must lose to the set.
      drive(1'b0, 4'h4, 1'b0, 1'b0);
      sample("bp_cap", 4'h4, 1'b0, 2'd2, D2, 1'b0);
      for (int j = 0; j < 50; j++) begin
         drive(1'b0, 4'hF, 1'b0, j == 20);
         sample($sformatf("bp%0d", j), 4'h0, 1'b1, 2'd2, D2, j >= TO);
      end
      drive(1'b0, 4'h0, 1'b1, 1'b1);
      sample("bp_clr", 4'h0, 1'b1, 2'd2, D2, 1'b1);
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      sample("bp_done", 4'h0, 1'b0, 2'd2, D2, 1'b0);

      // Reset in the middle of a stalled transfer with the flag set.
      drive(1'b0, 4'h2, 1'b0, 1'b0);
      sample("rs_cap", 4'h2, 1'b0, 2'd2, D2, 1'b0);
      for (int j = 0; j < 10; j++) begin
         drive(1'b0, 4'h0, 1'b0, 1'b0);
         sample($sformatf("rs%0d", j), 4'h0, 1'b1, 2'd1, D1, j >= TO);
      end
      drive(1'b1, 4'hF, 1'b0, 1'b0);
      sample("rs_assert", 4'h0, 1'b1, 2'd1, D1, 1'b1);
      drive(1'b0, 4'hF, 1'b1, 1'b0);
      sample("rs_after", 4'h1, 1'b0, 2'd0, 32'h0, 1'b0);
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      sample("rs_send", 4'h0, 1'b1, 2'd0, D0, 1'b0);

      // Randomized traffic against a transaction-level model.
      m_send = 1'b0; m_err = 1'b0; m_ptr = 1; m_wait = 0; m_gid = 2'd0; m_pl = D0;
      for (int c = 0; c < 3000; c++) begin
         rst        = (c == 0) || ($urandom_range(0, 199) == 0);
         req_valid  = 4'($urandom);
         sync_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
         err_clr    = ($urandom_range(0, 29) == 0);
         for (int i = 0; i < NR; i++) d[i] = $urandom;
         w    = (!rst && !m_send) ? pick(req_valid, m_ptr) : -1;
         e_rr = '0;
         if (w >= 0) e_rr[2'(w)] = 1'b1;
         sample("rnd", e_rr, m_send, m_gid, m_pl, m_err);
         if (rst) begin
            m_send = 1'b0; m_err = 1'b0; m_ptr = 0; m_wait = 0; m_gid = 2'd0; m_pl = '0;
         end else begin
            set = 1'b0;
            if (!m_send) begin
               if (w >= 0) begin
                  m_send = 1'b1; m_gid = 2'(w); m_pl = d[w];
                  m_ptr = (w + 1) % NR; m_wait = 0;
               end
            end else if (sync_ready) begin
               m_send = 1'b0;
            end else begin
               m_wait++;
               if (m_wait >= TO) set = 1'b1;
            end
            m_err = set ? 1'b1 : (err_clr ? 1'b0 : m_err);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
